// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and streak helper for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_ACK_I,
    ST_ACK_D,
    ST_HALTED
  } arb_state_t;

  localparam int STREAK_W = 4;

  // A data grant only extends the streak while fetch is actually waiting.
  function automatic logic [STREAK_W-1:0] streak_after_d(input logic [STREAK_W-1:0] streak,
                                                         input logic if_pending);
    if (!if_pending)
      return '0;
    else if (streak == {STREAK_W{1'b1}})
      return streak;
    else
      return streak + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises fetch and load/store accesses onto one memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    halt,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ack,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ack,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    halted
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  arb_state_t          state;
  logic [STREAK_W-1:0] streak;
  logic                d_wins;

  // Data has priority unless fetch has already been passed over LIMIT times in a row.
  assign d_wins = dm_req && !(if_req && (streak == LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (d_wins) begin
            state     <= ST_BUSY_D;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
            streak    <= streak_after_d(streak, if_req);
          end else if (if_req) begin
            state     <= ST_BUSY_I;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            streak    <= '0;
          end
        end
        ST_BUSY_I: begin
          if (mem_ready) begin
            state    <= ST_ACK_I;
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end
        end
        ST_BUSY_D: begin
          if (mem_ready) begin
            state    <= ST_ACK_D;
            mem_req  <= 1'b0;
            dm_rdata <= mem_rdata;
            dm_ack   <= 1'b1;
          end
        end
        ST_ACK_I, ST_ACK_D: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          busy   <= 1'b0;
          if (halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_wstrb = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        halted;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } grant_t;

  typedef struct {
    logic        is_d;
    logic        chk;
    logic [31:0] rdata;
  } ack_t;

  grant_t exp_grant[$];
  ack_t   exp_ack[$];
  int checks = 0;
  int errors = 0;
  int wait_states = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], 16'hC0DE};
  endfunction

  // Memory responder: asserts ready after wait_states cycles of mem_req.
  int resp_cnt = 0;
  always @(negedge clk) begin
    mem_rdata = model_rdata(mem_addr);
    if (mem_req && !reset) begin
      if (resp_cnt >= wait_states) begin
        mem_ready = 1'b1;
        resp_cnt  = 0;
      end else begin
        mem_ready = 1'b0;
        resp_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      resp_cnt  = 0;
    end
  end

  // Monitor: pops expectations on each new grant and each ack.
  grant_t cur;
  ack_t   ea;
  logic   in_burst = 1'b0;
  int     burst = 0;
  always @(negedge clk) begin
    if (reset) begin
      in_burst = 1'b0;
    end else begin
      if (mem_req && !in_burst) begin
        in_burst = 1'b1;
        burst = 1;
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
          cur = '{1'b0, mem_addr, mem_wdata, mem_wstrb, 0};
        end else begin
          cur = exp_grant.pop_front();
          chk("grant_we", {31'b0, mem_we}, {31'b0, cur.we});
          chk("grant_addr", mem_addr, cur.addr);
          chk("grant_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
          if (cur.we) chk("grant_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req && in_burst) begin
        burst++;
        chk("stable_addr", mem_addr, cur.addr);
        chk("stable_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
        if (cur.we) chk("stable_wdata", mem_wdata, cur.wdata);
      end else if (!mem_req && in_burst) begin
        in_burst = 1'b0;
        if (cur.len != 0) chk("req_cycles", burst, cur.len);
      end
      if (if_ack && dm_ack) chk("dual_ack", 32'd1, 32'd0);
      if (if_ack || dm_ack) begin
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", {31'b0, dm_ack}, 32'hFFFF_FFFF);
        end else begin
          ea = exp_ack.pop_front();
          chk("ack_port", {31'b0, dm_ack}, {31'b0, ea.is_d});
          if (ea.chk) chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, ea.rdata);
        end
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int len, input logic chk_data, input logic [31:0] rdata);
    exp_grant.push_back('{we, addr, wdata, wstrb, len});
    exp_ack.push_back('{is_d, chk_data, rdata});
  endtask

  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
    int n;
    dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_wstrb = wstrb; dm_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_ack && n < 200);
    if (!dm_ack) chk("dm_ack_timeout", 32'd0, 32'd1);
    dm_req = 1'b0;
  endtask

  task automatic i_fetch(input logic [31:0] addr);
    int n;
    if_addr = addr; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack && n < 200);
    if (!if_ack) chk("if_ack_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_acks", {30'b0, if_ack, dm_ack}, 32'd0);
    chk("rst_busy_halted", {30'b0, busy, halted}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, cycle-exact latency
    wait_states = 0;
    push_exp(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 1'b1, 32'h0000_0013);
    if_addr = 32'h100; if_req = 1'b1;
    @(negedge clk);
    chk("fetch_c1_mem_req", {31'b0, mem_req}, 32'd1);
    chk("fetch_c1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("fetch_c2_if_ack", {31'b0, if_ack}, 32'd1);
    chk("fetch_c2_if_rdata", if_rdata, 32'h0000_0013);
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_c3_idle", {30'b0, if_ack, busy}, 32'd0);

    // Store with two wait states
    wait_states = 2;
    push_exp(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 32'h0);
    d_access(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);

    // Contention with both requesters continuously asserting
    wait_states = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) push_exp(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1, 1'b1, 32'h0400_C0DE);
      else if (k == 9) push_exp(1'b0, 1'b0, 32'h404, 32'h0, 4'h0, 1, 1'b1, 32'h0404_C0DE);
      else begin
        automatic logic [31:0] a = 32'h300 + 32'(4 * (k < 4 ? k : k - 1));
        push_exp(1'b1, 1'b0, a, 32'h0, 4'h0, 1, 1'b1, {a[15:0], 16'hC0DE});
      end
    end
    fork
      for (int k = 0; k < 8; k++) d_access(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'h0);
      for (int k = 0; k < 2; k++) i_fetch(32'h400 + 32'(4 * k));
    join
    repeat (2) @(negedge clk);

    // Reset in the middle of a fetch abandons it
    wait_states = 6;
    exp_grant.push_back('{1'b0, 32'h500, 32'h0, 4'h0, 0});
    if_addr = 32'h500; if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 20);
    chk("midrst_granted", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_mem_req_drop", {31'b0, mem_req}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_ack_busy", {30'b0, if_ack, busy}, 32'd0);
    wait_states = 0;
    push_exp(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 1'b1, 32'h0000_0013);
    i_fetch(32'h100);
    @(negedge clk);

    // Halt during a data access: ack still delivered, then sticky halt
    wait_states = 2;
    push_exp(1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 3, 1'b1, 32'h0600_C0DE);
    fork
      d_access(1'b0, 32'h600, 32'h0, 4'h0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 20);
        halt = 1'b1;
      end
    join
    @(negedge clk);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_busy", {31'b0, busy}, 32'd0);
    if_addr = 32'h700; if_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("halt_no_grant", {31'b0, mem_req}, 32'd0);
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    chk("halt_no_ack", {31'b0, if_ack}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);

    chk("grants_left", exp_grant.size(), 32'd0);
    chk("acks_left", exp_ack.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
